// File: rtl/mult_booth_seq.sv
// -----------------------------------------------------------------------------
// mult_booth_seq
// Multi-cycle signed multiplier using radix-4 modified Booth recoding. Two
// multiplier bits are retired per cycle. The low WIDTH bits of the product and
// a signed-overflow flag are held in registers, and a one-cycle ready pulse
// marks the cycle in which they become valid.
//
// Ports:
//   clock           rising-edge clock
//   reset_n         asynchronous active-low reset
//   ctrl_MULT       start pulse; operands are sampled on the same edge
//   data_operandA   multiplicand, two's complement
//   data_operandB   multiplier, two's complement
//   data_result     low WIDTH bits of the product (registered, held)
//   data_exception  product does not fit in WIDTH signed bits (registered, held)
//   data_resultRDY  one-cycle pulse, result valid
//   busy            high while iterating
// -----------------------------------------------------------------------------
module mult_booth_seq #(
  parameter int WIDTH = 32,
  parameter int ITERS = WIDTH / 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ctrl_MULT,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int HW    = WIDTH + 2;       // accumulator half width
  localparam int PW    = 2 * WIDTH + 3;   // {acc, multiplier, guard bit}
  localparam int CNT_W = $clog2(ITERS);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                 state_q,  state_d;
  logic [CNT_W-1:0]       cnt_q,    cnt_d;
  logic signed [HW-1:0]   a_q,      a_d;
  logic signed [PW-1:0]   p_q,      p_d;
  logic [WIDTH-1:0]       result_q, result_d;
  logic                   exc_q,    exc_d;
  logic                   rdy_q,    rdy_d;
  logic                   busy_q,   busy_d;

  logic [2:0]             trip;
  logic [HW-1:0]          mult;
  logic                   neg;
  logic [HW-1:0]          sum;
  logic signed [PW-1:0]   p_step;
  logic [WIDTH:0]         prod_top;

  // Booth digit selection: negative multiples are formed as the bitwise
  // inverse, with the +1 supplied as carry-in to the accumulator add.
  always_comb begin
    trip = p_q[2:0];
    mult = '0;
    neg  = 1'b0;
    case (trip)
      3'b001, 3'b010: mult = a_q;
      3'b011:         mult = a_q <<< 1;
      3'b100:         begin mult = ~(a_q <<< 1); neg = 1'b1; end
      3'b101, 3'b110: begin mult = ~a_q;         neg = 1'b1; end
      default:        mult = '0;
    endcase
    sum    = p_q[PW-1:WIDTH+1] + mult + {{(HW-1){1'b0}}, neg};
    p_step = $signed({sum, p_q[WIDTH:0]}) >>> 2;
  end

  // Next-state logic. A start is honoured in every state; in RUN it aborts the
  // current operation, in DONE it overlaps the ready pulse of the finishing one.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    p_d      = p_q;
    result_d = result_q;
    exc_d    = exc_q;
    if (ctrl_MULT) begin
      a_d     = {{2{data_operandA[WIDTH-1]}}, data_operandA};
      p_d     = {{(WIDTH+2){1'b0}}, data_operandB, 1'b0};
      cnt_d   = '0;
      state_d = RUN;
    end else begin
      case (state_q)
        RUN: begin
          p_d   = p_step;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(ITERS - 1)) state_d = DONE;
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
    // After the final shift the product sits one bit up, above the leftover
    // multiplier sign bit, so product bit k is register bit k+1.
    prod_top = p_d[2*WIDTH:WIDTH];
    if (state_d == DONE) begin
      result_d = p_d[WIDTH:1];
      exc_d    = !((&prod_top) || !(|prod_top));
    end
    rdy_d  = (state_d == DONE);
    busy_d = (state_d == RUN);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      p_q      <= '0;
      result_q <= '0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      p_q      <= p_d;
      result_q <= result_d;
      exc_q    <= exc_d;
      rdy_q    <= rdy_d;
      busy_q   <= busy_d;
    end
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_mult_booth_seq.sv
module tb_mult_booth_seq;

  logic        clock;
  logic        reset_n;
  logic        ctrl_MULT;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  int total = 0;
  int bad   = 0;

  mult_booth_seq #(.WIDTH(32)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .ctrl_MULT      (ctrl_MULT),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        exc;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Drive a start pulse; returns in cycle 1 (one negedge after the start edge).
  task automatic start(input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT     = 1'b1;
    @(negedge clock);
    ctrl_MULT     = 1'b0;
  endtask

  // Full transaction: checks latency, busy during iteration, result, exception
  // and that RDY drops after one cycle.
  task automatic run_mul(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input logic exc);
    int  cyc;
    bit  busy_ok;
    start(a, b);
    cyc     = 1;
    busy_ok = 1'b1;
    while (data_resultRDY !== 1'b1 && cyc < 40) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(negedge clock);
      cyc++;
    end
    chk({name, " latency"}, cyc, 32'd17);
    chk({name, " busy"}, {31'd0, busy_ok}, 32'd1);
    chk({name, " busy_at_rdy"}, {31'd0, busy}, 32'd0);
    chk({name, " result"}, data_result, res);
    chk({name, " exc"}, {31'd0, data_exception}, {31'd0, exc});
    @(negedge clock);
    chk({name, " rdy_drop"}, {31'd0, data_resultRDY}, 32'd0);
  endtask

  initial begin
    int  saw;
    vecs[0]  = '{32'd6,        32'd7,        32'd42,       1'b0};
    vecs[1]  = '{32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1, 1'b0};
    vecs[2]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,        1'b0};
    vecs[3]  = '{32'h7FFFFFFF, 32'd2,        32'hFFFFFFFE, 1'b1};
    vecs[4]  = '{32'h00010000, 32'h00010000, 32'd0,        1'b1};
    vecs[5]  = '{32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1};
    vecs[6]  = '{32'h80000000, 32'd1,        32'h80000000, 1'b0};
    vecs[7]  = '{32'd0,        32'h00012345, 32'd0,        1'b0};
    vecs[8]  = '{32'h12345678, 32'd0,        32'd0,        1'b0};
    vecs[9]  = '{32'd123,      32'd456,      32'd56088,    1'b0};
    vecs[10] = '{32'hFFFFFFF9, 32'd3,        32'hFFFFFFEB, 1'b0};
    vecs[11] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'd1,        1'b1};
    vecs[12] = '{32'h40000000, 32'd2,        32'h80000000, 1'b1};
    vecs[13] = '{32'hC0000000, 32'd2,        32'h80000000, 1'b0};

    reset_n       = 1'b0;
    ctrl_MULT     = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    #23;
    chk("reset result", data_result, 32'd0);
    chk("reset exc", {31'd0, data_exception}, 32'd0);
    chk("reset rdy", {31'd0, data_resultRDY}, 32'd0);
    chk("reset busy", {31'd0, busy}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    // First operation with hold check out to cycle 20.
    run_mul("mul6x7", 32'd6, 32'd7, 32'd42, 1'b0);  // now in cycle 18
    @(negedge clock);
    @(negedge clock);                                // cycle 20
    chk("hold result", data_result, 32'd42);
    chk("hold rdy", {31'd0, data_resultRDY}, 32'd0);

    for (int i = 0; i < 14; i++)
      run_mul($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].exc);

    // Abort: restart in cycle 8 with 10 * -4.
    start(32'd6, 32'd7);
    for (int c = 1; c < 8; c++) @(negedge clock);
    data_operandA = 32'd10;
    data_operandB = 32'hFFFFFFFC;
    ctrl_MULT     = 1'b1;
    @(negedge clock);                                // cycle 9
    ctrl_MULT     = 1'b0;
    saw = 0;
    for (int c = 9; c < 25; c++) begin
      if (data_resultRDY === 1'b1) saw++;
      @(negedge clock);
    end
    chk("abort no_rdy", saw, 32'd0);
    chk("abort rdy25", {31'd0, data_resultRDY}, 32'd1);
    chk("abort result", data_result, 32'hFFFFFFD8);
    chk("abort exc", {31'd0, data_exception}, 32'd0);

    // Asynchronous reset mid-operation.
    start(32'd123, 32'd456);
    for (int c = 1; c < 5; c++) @(negedge clock);
    #3 reset_n = 1'b0;
    #1;
    chk("async result", data_result, 32'd0);
    chk("async busy", {31'd0, busy}, 32'd0);
    chk("async rdy", {31'd0, data_resultRDY}, 32'd0);
    #13 reset_n = 1'b1;
    saw = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clock);
      if (data_resultRDY === 1'b1 || busy === 1'b1) saw++;
    end
    chk("post_reset quiet", saw, 32'd0);
    run_mul("fresh123x456", 32'd123, 32'd456, 32'd56088, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
